// File: rtl/wavetable_loader_if.sv
// Byte-stream input and BRAM write-port bundle for the wavetable loader.
// master: stream source / write sink (front end + BRAM side).
// slave : the loader itself.
interface wavetable_loader_if #(
    parameter int D_W       = 16,
    parameter int ADDR_BITS = 8,
    parameter int WAVE_BITS = 2
);
    logic [7:0]           byte_in;
    logic                 byte_valid;
    logic                 byte_ready;
    logic                 wr_en;
    logic [WAVE_BITS-1:0] wr_wave;
    logic [ADDR_BITS-1:0] wr_addr;
    logic [D_W-1:0]       wr_data;

    modport master (
        output byte_in, byte_valid,
        input  byte_ready, wr_en, wr_wave, wr_addr, wr_data
    );

    modport slave (
        input  byte_in, byte_valid,
        output byte_ready, wr_en, wr_wave, wr_addr, wr_data
    );
endinterface

// File: rtl/wavetable_loader.sv
// wavetable_loader: parses framed bytes {CMD, START, COUNT, samples..., [CSUM]}
// into 16-bit samples and issues one-cycle writes to a 256x16 wavetable BRAM.
// Optional feature: define WAVETABLE_LOADER_CHECKSUM_EN to require a trailing
// XOR checksum byte over all sample bytes of the frame.
module wavetable_loader #(
    parameter int D_W       = 16,
    parameter int ADDR_BITS = 8,
    parameter int SAMPLE_CT = 256,
    parameter int WAVE_BITS = 2
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    wavetable_loader_if.slave  bus,
    output logic               busy,
    output logic               load_done,
    output logic               frame_err
);
    localparam logic [3:0] CMD_TAG = 4'hA;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_COUNT,
        S_DATA_HI,
        S_DATA_LO,
`ifdef WAVETABLE_LOADER_CHECKSUM_EN
        S_CSUM,
`endif
        S_DONE
    } state_t;

    state_t               state_reg, state_next;
    logic                 xfer;
    logic                 cmd_ok, cmd_bad, take_addr, take_count, take_hi, take_lo;
    logic                 last_sample;
    logic [WAVE_BITS-1:0] wave_reg;
    logic [ADDR_BITS-1:0] addr_reg;
    logic [7:0]           remain_reg;
    logic [7:0]           msb_reg;
`ifdef WAVETABLE_LOADER_CHECKSUM_EN
    logic                 take_csum;
    logic [7:0]           csum_reg;
`endif

    // remain_reg counts samples still to come after the current one
    assign last_sample = (remain_reg == 8'd0);

    // State register
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) state_reg <= S_IDLE;
        else            state_reg <= state_next;
    end

    // Next-state decode and per-byte strobes for the datapath
    always_comb begin
        state_next     = state_reg;
        cmd_ok         = 1'b0;
        cmd_bad        = 1'b0;
        take_addr      = 1'b0;
        take_count     = 1'b0;
        take_hi        = 1'b0;
        take_lo        = 1'b0;
`ifdef WAVETABLE_LOADER_CHECKSUM_EN
        take_csum      = 1'b0;
`endif
        bus.byte_ready = sys_rst_n && (state_reg != S_DONE);
        busy           = (state_reg != S_IDLE);
        xfer           = bus.byte_valid && bus.byte_ready;
        case (state_reg)
            S_IDLE: if (xfer) begin
                if (bus.byte_in[7:4] == CMD_TAG) begin
                    cmd_ok     = 1'b1;
                    state_next = S_ADDR;
                end else begin
                    cmd_bad    = 1'b1;
                end
            end
            S_ADDR: if (xfer) begin
                take_addr  = 1'b1;
                state_next = S_COUNT;
            end
            S_COUNT: if (xfer) begin
                take_count = 1'b1;
                state_next = S_DATA_HI;
            end
            S_DATA_HI: if (xfer) begin
                take_hi    = 1'b1;
                state_next = S_DATA_LO;
            end
            S_DATA_LO: if (xfer) begin
                take_lo = 1'b1;
                if (last_sample) begin
`ifdef WAVETABLE_LOADER_CHECKSUM_EN
                    state_next = S_CSUM;
`else
                    state_next = S_DONE;
`endif
                end else begin
                    state_next = S_DATA_HI;
                end
            end
`ifdef WAVETABLE_LOADER_CHECKSUM_EN
            S_CSUM: if (xfer) begin
                take_csum  = 1'b1;
                state_next = S_DONE;
            end
`endif
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Frame datapath: latch header fields, assemble samples, drive the write port
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            wave_reg     <= '0;
            addr_reg     <= '0;
            remain_reg   <= '0;
            msb_reg      <= '0;
            bus.wr_en    <= 1'b0;
            bus.wr_wave  <= '0;
            bus.wr_addr  <= '0;
            bus.wr_data  <= '0;
            load_done    <= 1'b0;
            frame_err    <= 1'b0;
`ifdef WAVETABLE_LOADER_CHECKSUM_EN
            csum_reg     <= '0;
`endif
        end else begin
            bus.wr_en <= 1'b0;
            load_done <= 1'b0;
            frame_err <= cmd_bad;
            if (cmd_ok) begin
                wave_reg <= bus.byte_in[WAVE_BITS-1:0];
`ifdef WAVETABLE_LOADER_CHECKSUM_EN
                csum_reg <= '0;
`endif
            end
            if (take_addr)  addr_reg   <= ADDR_BITS'(bus.byte_in);
            if (take_count) remain_reg <= bus.byte_in;
            if (take_hi) begin
                msb_reg <= bus.byte_in;
`ifdef WAVETABLE_LOADER_CHECKSUM_EN
                csum_reg <= csum_reg ^ bus.byte_in;
`endif
            end
            if (take_lo) begin
                bus.wr_en   <= 1'b1;
                bus.wr_wave <= wave_reg;
                bus.wr_addr <= addr_reg;
                bus.wr_data <= D_W'({msb_reg, bus.byte_in});
                addr_reg    <= (addr_reg == ADDR_BITS'(SAMPLE_CT - 1))
                               ? '0 : addr_reg + ADDR_BITS'(1);
                remain_reg  <= remain_reg - 8'd1;
`ifdef WAVETABLE_LOADER_CHECKSUM_EN
                csum_reg    <= csum_reg ^ bus.byte_in;
`else
                if (last_sample) load_done <= 1'b1;
`endif
            end
`ifdef WAVETABLE_LOADER_CHECKSUM_EN
            if (take_csum) begin
                if (bus.byte_in == csum_reg) load_done <= 1'b1;
                else                         frame_err <= 1'b1;
            end
`endif
        end
    end
endmodule

// File: tb/tb_wavetable_loader.sv
// Testbench for wavetable_loader: directed frames plus randomized frames and
// idle gaps, checked against a frame-parsing reference model.
module tb_wavetable_loader;
`ifdef WAVETABLE_LOADER_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy, load_done, frame_err;
    always #5 clk = ~clk;

    wavetable_loader_if ifc ();

    wavetable_loader dut (
        .sys_clk   (clk),
        .sys_rst_n (rst_n),
        .bus       (ifc),
        .busy      (busy),
        .load_done (load_done),
        .frame_err (frame_err)
    );

    int errors = 0;
    int checks = 0;
    logic [25:0] exp_q[$];
    logic [25:0] act_q[$];
    int exp_ld, exp_fe, act_ld, act_fe;

    // Monitor: collect writes and pulses mid-cycle
    always @(negedge clk) begin
        if (ifc.wr_en) act_q.push_back({ifc.wr_wave, ifc.wr_addr, ifc.wr_data});
        if (load_done) act_ld++;
        if (frame_err) act_fe++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Build a byte queue from a packed vector, most significant byte first
    function automatic bq_t mk(input logic [63:0] v, input int n);
        bq_t r;
        for (int i = 0; i < n; i++) r.push_back(v[8*(n-1-i) +: 8]);
        return r;
    endfunction

    // Append the XOR of sample bytes when the checksum feature is built in
    function automatic bq_t with_csum(input bq_t s);
        bq_t r = s;
        logic [7:0] x = 8'h00;
        for (int i = 3; i < s.size(); i++) x = x ^ s[i];
        if (CSUM_EN) r.push_back(x);
        return r;
    endfunction

    // Reference model: parse a complete byte stream into expected writes/pulses
    function automatic void model(input bq_t s);
        int idx = 0;
        exp_q.delete();
        exp_ld = 0;
        exp_fe = 0;
        while (idx < s.size()) begin
            logic [7:0] b, addr, cnt, hi, lo, x;
            logic [1:0] wave;
            b = s[idx]; idx++;
            if (b[7:4] != 4'hA) begin
                exp_fe++;
                continue;
            end
            wave = b[1:0];
            addr = s[idx]; idx++;
            cnt  = s[idx]; idx++;
            x = 8'h00;
            for (int k = 0; k <= int'(cnt); k++) begin
                hi = s[idx]; lo = s[idx+1]; idx += 2;
                exp_q.push_back({wave, addr, hi, lo});
                x = x ^ hi ^ lo;
                addr = addr + 8'd1;
            end
            if (CSUM_EN) begin
                if (s[idx] == x) exp_ld++;
                else             exp_fe++;
                idx++;
            end else begin
                exp_ld++;
            end
        end
    endfunction

    task automatic clear_actual();
        act_q.delete();
        act_ld = 0;
        act_fe = 0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok = 1'b0;
        int n = 0;
        ifc.byte_valid = 1'b0;
        repeat (gap) begin @(posedge clk); #1; end
        ifc.byte_in    = b;
        ifc.byte_valid = 1'b1;
        while (!ok && n < 40) begin
            if (ifc.byte_ready) ok = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        ifc.byte_valid = 1'b0;
        if (!ok) chk("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic compare(input string tag);
        repeat (3) begin @(posedge clk); #1; end
        chk({tag, "_nwrites"}, act_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < act_q.size(); i++)
            chk({tag, "_write"}, 32'(act_q[i]), 32'(exp_q[i]));
        chk({tag, "_load_done"}, act_ld, exp_ld);
        chk({tag, "_frame_err"}, act_fe, exp_fe);
    endtask

    task automatic run_stream(input string tag, input bq_t s, input int max_gap);
        model(s);
        clear_actual();
        foreach (s[i]) send_byte(s[i], int'($urandom_range(max_gap, 0)));
        compare(tag);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_wr_en"},      ifc.wr_en,      1'b0);
        chk({tag, "_wr_wave"},    ifc.wr_wave,    2'd0);
        chk({tag, "_wr_addr"},    ifc.wr_addr,    8'd0);
        chk({tag, "_wr_data"},    ifc.wr_data,    16'd0);
        chk({tag, "_busy"},       busy,           1'b0);
        chk({tag, "_load_done"},  load_done,      1'b0);
        chk({tag, "_frame_err"},  frame_err,      1'b0);
        chk({tag, "_byte_ready"}, ifc.byte_ready, 1'b0);
    endtask

    initial begin
        bq_t s;
        logic [7:0] hdr, x;
        int cnt;

        ifc.byte_in    = 8'h00;
        ifc.byte_valid = 1'b0;
        rst_n          = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check_reset_outputs("reset");
        rst_n = 1'b1;
        #1;
        chk("reset_release_ready", ifc.byte_ready, 1'b1);
        chk("reset_release_busy", busy, 1'b0);

        // Directed frame with cycle-accurate write/done timing
        s = with_csum(mk(64'hA1_10_01_12_34_80_00, 7));
        model(s);
        clear_actual();
        for (int i = 0; i < 5; i++) send_byte(s[i], 0);
        chk("t1_w0_en",   ifc.wr_en,   1'b1);
        chk("t1_w0_addr", ifc.wr_addr, 8'h10);
        chk("t1_w0_data", ifc.wr_data, 16'h1234);
        chk("t1_w0_busy", busy,        1'b1);
        send_byte(s[5], 0);
        send_byte(s[6], 0);
        chk("t1_w1_en",        ifc.wr_en,      1'b1);
        chk("t1_w1_wave",      ifc.wr_wave,    2'd1);
        chk("t1_w1_addr",      ifc.wr_addr,    8'h11);
        chk("t1_w1_data",      ifc.wr_data,    16'h8000);
        chk("t1_w1_load_done", load_done,      !CSUM_EN);
        chk("t1_w1_busy",      busy,           1'b1);
        chk("t1_w1_ready",     ifc.byte_ready, CSUM_EN);
`ifdef WAVETABLE_LOADER_CHECKSUM_EN
        send_byte(s[7], 0);
        chk("t1_csum_load_done", load_done, 1'b1);
        chk("t1_csum_wr_en",     ifc.wr_en, 1'b0);
`endif
        @(posedge clk); #1;
        chk("t1_idle_busy",      busy,        1'b0);
        chk("t1_idle_wr_en",     ifc.wr_en,   1'b0);
        chk("t1_idle_addr_hold", ifc.wr_addr, 8'h11);
        chk("t1_idle_data_hold", ifc.wr_data, 16'h8000);
        chk("t1_idle_load_done", load_done,   1'b0);
        compare("t1");

        // Address wrap 0xFF -> 0x00
        run_stream("t2", with_csum(mk(64'hA3_FF_01_00_01_00_02, 7)), 0);

        // Bad header byte, then a good frame
        s = with_csum(mk(64'hA0_05_00_7F_FF, 5));
        s.push_front(8'h37);
        model(s);
        clear_actual();
        send_byte(s[0], 0);
        chk("t3_frame_err", frame_err, 1'b1);
        chk("t3_busy",      busy,      1'b0);
        chk("t3_wr_en",     ifc.wr_en, 1'b0);
        for (int i = 1; i < s.size(); i++) send_byte(s[i], 0);
        compare("t3");

        // Same as the first frame with random idle gaps
        repeat (3) run_stream("t4", with_csum(mk(64'hA1_10_01_12_34_80_00, 7)), 3);

        // Randomized frames, optional bad headers, random gaps
        repeat (8) begin
            s.delete();
            if ($urandom_range(3, 0) == 0) begin
                hdr = 8'($urandom);
                if (hdr[7:4] == 4'hA) hdr[7] = ~hdr[7];
                s.push_back(hdr);
            end
            s.push_back({4'hA, 2'($urandom), 2'($urandom)});
            if ($urandom_range(1, 0) == 1) s.push_back(8'($urandom));
            else                           s.push_back(8'hFC + 8'($urandom_range(3, 0)));
            cnt = int'($urandom_range(6, 0));
            s.push_back(8'(cnt));
            x = 8'h00;
            for (int k = 0; k < 2 * (cnt + 1); k++) begin
                hdr = 8'($urandom);
                s.push_back(hdr);
                x = x ^ hdr;
            end
            if (CSUM_EN) s.push_back(($urandom_range(2, 0) == 0) ? (x ^ 8'h01) : x);
            run_stream("rand", s, 3);
        end

        // Maximum count: 256 samples covering the whole table
        s = mk(64'hA2_00_FF, 3);
        for (int k = 0; k < 256; k++) begin
            s.push_back(8'(k ^ 8'h5A));
            s.push_back(8'(k));
        end
        run_stream("max_count", with_csum(s), 0);

        // Reset in the middle of a sample
        clear_actual();
        s = mk(64'hA2_20_00_12, 4);
        foreach (s[i]) send_byte(s[i], 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("t5_rst");
        rst_n = 1'b1;
        #1;
        chk("t5_release_ready", ifc.byte_ready, 1'b1);
        chk("t5_no_partial_write", act_q.size(), 0);
        run_stream("t5", with_csum(mk(64'hA2_20_00_AB_CD, 5)), 1);

`ifdef WAVETABLE_LOADER_CHECKSUM_EN
        run_stream("t6_good", mk(64'hA0_00_00_12_34_26, 6), 0);
        run_stream("t6_bad",  mk(64'hA0_00_00_12_34_27, 6), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
